// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: field widths, kind codes,
// opcodes and FSM state encoding. ERROR state exists only with ENC_ILLEGAL_TRAP_EN.
package encoder_pkg;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int KIND_W   = 4;
  localparam int OP_W     = 6;
  localparam int REG_W    = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;
  localparam int COUNT_W  = 16;

  localparam logic [KIND_W-1:0] KIND_R    = 4'd0;
  localparam logic [KIND_W-1:0] KIND_LW   = 4'd1;
  localparam logic [KIND_W-1:0] KIND_SW   = 4'd2;
  localparam logic [KIND_W-1:0] KIND_ADDI = 4'd3;
  localparam logic [KIND_W-1:0] KIND_SLTI = 4'd4;
  localparam logic [KIND_W-1:0] KIND_BEQ  = 4'd5;
  localparam logic [KIND_W-1:0] KIND_BNE  = 4'd6;
  localparam logic [KIND_W-1:0] KIND_BGE  = 4'd7;
  localparam logic [KIND_W-1:0] KIND_BGT  = 4'd8;
  localparam logic [KIND_W-1:0] KIND_J    = 4'd9;

  localparam logic [OP_W-1:0] OP_R    = 6'h00;
  localparam logic [OP_W-1:0] OP_LW   = 6'h23;
  localparam logic [OP_W-1:0] OP_SW   = 6'h2B;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI = 6'h0A;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE  = 6'h05;
  localparam logic [OP_W-1:0] OP_BGE  = 6'h01;
  localparam logic [OP_W-1:0] OP_BGT  = 6'h07;
  localparam logic [OP_W-1:0] OP_J    = 6'h02;

  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

`ifdef ENC_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE, ST_ERROR
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE
  } state_e;
`endif

endpackage

// File: rtl/instr_encoder_if.sv
// Program-load bus of the instruction encoder: control, instruction beats,
// instruction-memory write port and status. master drives beats, slave is the encoder.
interface instr_encoder_if;
  import encoder_pkg::*;

  logic                start_i;
  logic [ADDR_W-1:0]   base_addr_i;
  logic                in_valid_i;
  logic                in_ready_o;
  logic                last_i;
  logic [KIND_W-1:0]   kind_i;
  logic [REG_W-1:0]    rs_i;
  logic [REG_W-1:0]    rt_i;
  logic [REG_W-1:0]    rd_i;
  logic [REG_W-1:0]    shamt_i;
  logic [FUNCT_W-1:0]  funct_i;
  logic [IMM_W-1:0]    imm_i;
  logic [TARGET_W-1:0] target_i;
  logic                wr_en_o;
  logic [ADDR_W-1:0]   wr_addr_o;
  logic [WORD_W-1:0]   wr_data_o;
  logic                wr_ack_i;
  logic                busy_o;
  logic                done_o;
  logic                err_o;
  logic [COUNT_W-1:0]  count_o;

  modport master (
    output start_i, base_addr_i, in_valid_i, last_i, kind_i, rs_i, rt_i, rd_i,
           shamt_i, funct_i, imm_i, target_i, wr_ack_i,
    input  in_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o, count_o
  );

  modport slave (
    input  start_i, base_addr_i, in_valid_i, last_i, kind_i, rs_i, rt_i, rd_i,
           shamt_i, funct_i, imm_i, target_i, wr_ack_i,
    output in_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o, count_o
  );

endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational packing of an instruction kind and its fields into a 32-bit word.
// Unknown kinds produce an all-zero word and raise the illegal flag.
module instr_field_pack
  import encoder_pkg::*;
(
  input  logic [KIND_W-1:0]   kind,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    shamt,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [IMM_W-1:0]    imm,
  input  logic [TARGET_W-1:0] target,
  output logic [WORD_W-1:0]   word,
  output logic                illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_R:    word = {OP_R, rs, rt, rd, shamt, funct};
      KIND_LW:   word = {OP_LW, rs, rt, imm};
      KIND_SW:   word = {OP_SW, rs, rt, imm};
      KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
      KIND_SLTI: word = {OP_SLTI, rs, rt, imm};
      KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
      KIND_BNE:  word = {OP_BNE, rs, rt, imm};
      KIND_BGE:  word = {OP_BGE, rs, rt, imm};
      KIND_BGT:  word = {OP_BGT, rs, rt, imm};
      KIND_J:    word = {OP_J, target};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: beat handshake, one-entry write register, pointer/counter
// and load FSM. Define ENC_ILLEGAL_TRAP_EN to trap illegal kinds into an ERROR state.
module instr_encoder
  import encoder_pkg::*;
(
  input logic            clk_i,
  input logic            rst_i,
  instr_encoder_if.slave bus
);

  state_e              state;
  logic                out_full;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [WORD_W-1:0]   wr_word;
  logic [COUNT_W-1:0]  count;
  logic                done;
  logic [WORD_W-1:0]   pack_word;
  logic [WORD_W-1:0]   enc_word;
  logic                pack_illegal;
  logic                accept;
  logic                ack;
  logic                load;

  instr_field_pack u_pack (
    .kind    (bus.kind_i),
    .rs      (bus.rs_i),
    .rt      (bus.rt_i),
    .rd      (bus.rd_i),
    .shamt   (bus.shamt_i),
    .funct   (bus.funct_i),
    .imm     (bus.imm_i),
    .target  (bus.target_i),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // An ack only counts while a word is actually being offered.
  assign ack            = bus.wr_ack_i && out_full;
  assign bus.in_ready_o = (state == ST_RUN) && (!out_full || bus.wr_ack_i);
  assign accept         = bus.in_valid_i && bus.in_ready_o;

`ifdef ENC_ILLEGAL_TRAP_EN
  logic err;
  assign enc_word   = pack_word;
  assign load       = accept && !pack_illegal;
  assign bus.err_o  = err;
`else
  // Illegal kinds become a nop word and are written like any other instruction.
  assign enc_word   = pack_illegal ? '0 : pack_word;
  assign load       = accept;
  assign bus.err_o  = 1'b0;
`endif

  assign bus.wr_en_o   = out_full;
  assign bus.wr_addr_o = wr_ptr;
  assign bus.wr_data_o = wr_word;
  assign bus.busy_o    = (state != ST_IDLE);
  assign bus.done_o    = done;
  assign bus.count_o   = count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      out_full <= 1'b0;
      wr_ptr   <= '0;
      wr_word  <= '0;
      count    <= '0;
      done     <= 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      // Ack retires the entry; a same-cycle load below refills it with no bubble.
      if (ack) begin
        out_full <= 1'b0;
        wr_ptr   <= wr_ptr + 32'd4;
        if (count != COUNT_MAX) count <= count + 16'd1;
      end
      if (load) begin
        out_full <= 1'b1;
        wr_word  <= enc_word;
      end

      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            state  <= ST_RUN;
            wr_ptr <= bus.base_addr_i;
            count  <= '0;
`ifdef ENC_ILLEGAL_TRAP_EN
            err    <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (accept) begin
`ifdef ENC_ILLEGAL_TRAP_EN
            if (pack_illegal) begin
              err   <= 1'b1;
              state <= (out_full && !bus.wr_ack_i) ? ST_DRAIN : ST_ERROR;
            end else if (bus.last_i) begin
              state <= ST_DRAIN;
            end
`else
            if (bus.last_i) state <= ST_DRAIN;
`endif
          end
        end
        ST_DRAIN: begin
          if (!out_full || ack) begin
`ifdef ENC_ILLEGAL_TRAP_EN
            if (err) begin
              state <= ST_ERROR;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
`else
            state <= ST_DONE;
            done  <= 1'b1;
`endif
          end
        end
        ST_DONE: state <= ST_IDLE;
`ifdef ENC_ILLEGAL_TRAP_EN
        ST_ERROR: begin
          if (bus.start_i) begin
            state  <= ST_RUN;
            wr_ptr <= bus.base_addr_i;
            count  <= '0;
            err    <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table of encoded instructions run as
// programs, plus hand-written backpressure, wrap, illegal-kind and reset sequences.
module tb_instr_encoder;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp_word;
  } vec_t;

  localparam int NVEC = 11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vec [NVEC];

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input vec_t v, input logic last);
    bus.in_valid_i = 1'b1;
    bus.last_i     = last;
    bus.kind_i     = v.kind;
    bus.rs_i       = v.rs;
    bus.rt_i       = v.rt;
    bus.rd_i       = v.rd;
    bus.shamt_i    = v.shamt;
    bus.funct_i    = v.funct;
    bus.imm_i      = v.imm;
    bus.target_i   = v.target;
  endtask

  task automatic pulse_start(input logic [31:0] base);
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.base_addr_i = base;
    @(negedge clk);
    bus.start_i     = 1'b0;
  endtask

  // Runs vec[first .. first+n-1] as one program with the write port always acking.
  task automatic run_program(input logic [31:0] base, input int first, input int n);
    bus.wr_ack_i = 1'b1;
    pulse_start(base);
    for (int i = 0; i < n; i++) begin
      drive_beat(vec[first+i], (i == n-1));
      #1 check("in_ready_run", {31'd0, bus.in_ready_o}, 32'd1);
      @(negedge clk);
      check("wr_en", {31'd0, bus.wr_en_o}, 32'd1);
      check("wr_data", bus.wr_data_o, vec[first+i].exp_word);
      check("wr_addr", bus.wr_addr_o, base + 32'(4*i));
    end
    bus.in_valid_i = 1'b0;
    bus.last_i     = 1'b0;
    @(negedge clk);
    check("done_pulse", {31'd0, bus.done_o}, 32'd1);
    check("count", {16'd0, bus.count_o}, 32'(n));
    @(negedge clk);
    check("done_clear", {31'd0, bus.done_o}, 32'd0);
    check("busy_idle", {31'd0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    // kind, rs, rt, rd, shamt, funct, imm, target, expected word
    vec[0]  = '{4'd3, 5'd0,  5'd8,  5'd31, 5'd31, 6'h3F, 16'h0005, 26'h3FFFFFF, 32'h20080005};
    vec[1]  = '{4'd0, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'hFFFF, 26'h0,       32'h00221820};
    vec[2]  = '{4'd1, 5'd29, 5'd9,  5'd0,  5'd0,  6'h00, 16'h0004, 26'h0,       32'h8FA90004};
    vec[3]  = '{4'd2, 5'd29, 5'd31, 5'd0,  5'd0,  6'h00, 16'h0008, 26'h0,       32'hAFBF0008};
    vec[4]  = '{4'd4, 5'd4,  5'd5,  5'd0,  5'd0,  6'h00, 16'h8000, 26'h0,       32'h28858000};
    vec[5]  = '{4'd5, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h1022FFFF};
    vec[6]  = '{4'd6, 5'd3,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0010, 26'h0,       32'h14600010};
    vec[7]  = '{4'd7, 5'd2,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0003, 26'h0,       32'h04400003};
    vec[8]  = '{4'd8, 5'd7,  5'd6,  5'd0,  5'd0,  6'h00, 16'h1234, 26'h0,       32'h1CE61234};
    vec[9]  = '{4'd9, 5'd31, 5'd31, 5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0000400, 32'h08000400};
    vec[10] = '{4'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0000, 26'h0,       32'h03FFFFFF};

    rst = 1'b1;
    bus.start_i = 1'b0; bus.base_addr_i = '0; bus.in_valid_i = 1'b0; bus.last_i = 1'b0;
    bus.kind_i = '0; bus.rs_i = '0; bus.rt_i = '0; bus.rd_i = '0; bus.shamt_i = '0;
    bus.funct_i = '0; bus.imm_i = '0; bus.target_i = '0; bus.wr_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
    check("rst_wr_addr", bus.wr_addr_o, 32'd0);
    check("rst_wr_data", bus.wr_data_o, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_err", {31'd0, bus.err_o}, 32'd0);
    check("rst_count", {16'd0, bus.count_o}, 32'd0);
    drive_beat(vec[0], 1'b1);
    #1 check("idle_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    check("idle_no_write", {31'd0, bus.wr_en_o}, 32'd0);

    $display("[TB] single addi at base 0");
    run_program(32'h0, 0, 1);
    $display("[TB] R + lw at base 0x100");
    run_program(32'h100, 1, 2);
    $display("[TB] full table at base 0x400");
    run_program(32'h400, 0, NVEC);
    $display("[TB] address wrap");
    run_program(32'hFFFFFFFC, 3, 2);

    $display("[TB] backpressure with beq");
    bus.wr_ack_i = 1'b0;
    pulse_start(32'h200);
    drive_beat(vec[5], 1'b0);
    @(negedge clk);
    drive_beat(vec[0], 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        bus.start_i     = 1'b1;
        bus.base_addr_i = 32'hDEAD0000;
      end else begin
        bus.start_i     = 1'b0;
      end
      if (c == 3) bus.wr_ack_i = 1'b1;
      #1;
      check("hold_wr_en", {31'd0, bus.wr_en_o}, 32'd1);
      check("hold_wr_data", bus.wr_data_o, 32'h1022FFFF);
      check("hold_wr_addr", bus.wr_addr_o, 32'h200);
      check("hold_in_ready", {31'd0, bus.in_ready_o}, (c == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    bus.start_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.last_i     = 1'b0;
    check("refill_data", bus.wr_data_o, 32'h20080005);
    check("refill_addr", bus.wr_addr_o, 32'h204);
    @(negedge clk);
    check("bp_done", {31'd0, bus.done_o}, 32'd1);
    check("bp_count", {16'd0, bus.count_o}, 32'd2);
    @(negedge clk);
    check("bp_idle", {31'd0, bus.busy_o}, 32'd0);

    $display("[TB] illegal kind 12");
    bus.wr_ack_i = 1'b1;
    pulse_start(32'h300);
    drive_beat('{4'd12, 5'd1, 5'd2, 5'd3, 5'd4, 6'h3F, 16'hABCD, 26'h1234567, 32'h0}, 1'b1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.last_i     = 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
    check("ill_no_write", {31'd0, bus.wr_en_o}, 32'd0);
    check("ill_err", {31'd0, bus.err_o}, 32'd1);
    @(negedge clk);
    check("ill_busy", {31'd0, bus.busy_o}, 32'd1);
    check("ill_no_done", {31'd0, bus.done_o}, 32'd0);
    check("ill_err_sticky", {31'd0, bus.err_o}, 32'd1);
    pulse_start(32'h600);
    check("ill_restart_err", {31'd0, bus.err_o}, 32'd0);
    check("ill_restart_ptr", bus.wr_addr_o, 32'h600);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`else
    check("ill_wr_en", {31'd0, bus.wr_en_o}, 32'd1);
    check("ill_nop", bus.wr_data_o, 32'h0);
    check("ill_addr", bus.wr_addr_o, 32'h300);
    check("ill_err", {31'd0, bus.err_o}, 32'd0);
    @(negedge clk);
    check("ill_done", {31'd0, bus.done_o}, 32'd1);
    check("ill_count", {16'd0, bus.count_o}, 32'd1);
    @(negedge clk);
`endif

    $display("[TB] reset during pending write");
    bus.wr_ack_i = 1'b0;
    pulse_start(32'h500);
    drive_beat(vec[4], 1'b1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.last_i     = 1'b0;
    check("pend_wr_en", {31'd0, bus.wr_en_o}, 32'd1);
    check("pend_addr", bus.wr_addr_o, 32'h500);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("mid_rst_count", {16'd0, bus.count_o}, 32'd0);
    check("mid_rst_addr", bus.wr_addr_o, 32'd0);
    check("mid_rst_data", bus.wr_data_o, 32'd0);
    check("mid_rst_ready", {31'd0, bus.in_ready_o}, 32'd0);
    bus.wr_ack_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_no_write", {31'd0, bus.wr_en_o}, 32'd0);
      check("post_rst_count", {16'd0, bus.count_o}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
